// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with buffered MDU results
// onto the single register-file write port, with starvation protection for the MDU FIFO.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_sel,
  input  logic [31:0]              alu_dat,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_sel,
  input  logic [31:0]              mdu_dat,
  output logic                     WEN,
  output logic [4:0]               wsel,
  output logic [31:0]              wdat,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    sel_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic fifo_empty, fifo_full, force_pop, alu_win, pop, push;

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL);

  // A starved head overrides the ALU; an ALU x0 result never blocks the head.
  assign force_pop = (starve_cnt == SMAX) && !fifo_empty;
  assign alu_ready = rst || !force_pop;
  assign mdu_ready = !rst && !fifo_full;
  assign alu_win   = !rst && !force_pop && alu_valid && (alu_sel != 5'd0);
  assign pop       = !rst && !fifo_empty && !alu_win;
  assign push      = mdu_valid && mdu_ready && (mdu_sel != 5'd0);

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) pend_mask[sel_mem[i]] = 1'b1;
  end

  // Payload storage needs no reset; occupancy is tracked by vld/count.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr] <= mdu_sel;
      dat_mem[wr_ptr] <= mdu_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (fifo_empty || pop)
      starve_cnt <= '0;
    else if (starve_cnt != SMAX)
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WEN  <= 1'b0;
      wsel <= '0;
      wdat <= '0;
    end else if (alu_win) begin
      WEN  <= 1'b1;
      wsel <= alu_sel;
      wdat <= alu_dat;
    end else if (pop) begin
      WEN  <= 1'b1;
      wsel <= sel_mem[rd_ptr];
      wdat <= dat_mem[rd_ptr];
    end else begin
      WEN  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_sel;
  logic [31:0] alu_dat;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_sel;
  logic [31:0] mdu_dat;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;

  int errs = 0;
  int checks = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_dat(alu_dat),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_sel(mdu_sel), .mdu_dat(mdu_dat),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue of {sel,dat}, plus starvation count and write port.
  logic [36:0] m_q[$];
  int          m_starve = 0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_wsel = '0;
  logic [31:0] m_wdat = '0;

  function automatic bit m_force();
    return (m_starve == STARVE_MAX) && (m_q.size() != 0);
  endfunction

  function automatic logic m_alu_ready();
    return rst ? 1'b1 : !m_force();
  endfunction

  function automatic logic m_mdu_ready();
    return !rst && (m_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (m_q[i]) p[m_q[i][36:32]] = 1'b1;
    return p;
  endfunction

  // Advance the model with the current inputs, then cross one rising edge.
  task automatic tick();
    bit frc, win, pop, rdy;
    logic [36:0] h;
    frc = m_force();
    if (rst) begin
      m_q.delete();
      m_starve = 0;
      m_wen = 1'b0; m_wsel = '0; m_wdat = '0;
    end else begin
      win = !frc && alu_valid && (alu_sel != 5'd0);
      pop = (m_q.size() != 0) && !win;
      rdy = m_q.size() < DEPTH;
      if (win) begin
        m_wen = 1'b1; m_wsel = alu_sel; m_wdat = alu_dat;
      end else if (pop) begin
        h = m_q[0];
        m_wen = 1'b1; m_wsel = h[36:32]; m_wdat = h[31:0];
      end else begin
        m_wen = 1'b0;
      end
      if (m_q.size() == 0 || pop) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      if (pop) void'(m_q.pop_front());
      if (mdu_valid && rdy && mdu_sel != 5'd0) m_q.push_back({mdu_sel, mdu_dat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b1; alu_sel = 5'd5; alu_dat = 32'h1;
    mdu_valid = 1'b1; mdu_sel = 5'd3; mdu_dat = 32'h2;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
    checks++; if (mdu_ready !== 1'b0) begin errs++; $display("FAIL reset_mdu_ready: got %b want 0", mdu_ready); end
    tick();
    tick();
    checks++; if (WEN !== 1'b0) begin errs++; $display("FAIL reset_wen: got %b want 0", WEN); end
    checks++; if (fifo_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (wsel !== 5'd0 || wdat !== 32'd0) begin errs++; $display("FAIL reset_wport: got %0d/%h want 0/0", wsel, wdat); end
    rst = 1'b0; alu_valid = 1'b0; mdu_valid = 1'b0;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errs++; $display("FAIL release_mdu_ready: got %b want 1", mdu_ready); end
    checks++; if (pend_mask !== 32'd0) begin errs++; $display("FAIL release_pend: got %h want 0", pend_mask); end
    checks++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL release_alu_ready: got %b want 1", alu_ready); end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_sel = 5'd5; alu_dat = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    checks++; if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'hDEADBEEF)
      begin errs++; $display("FAIL alu_write: got %b/%0d/%h want 1/5/deadbeef", WEN, wsel, wdat); end
    tick();
    checks++; if (WEN !== 1'b0) begin errs++; $display("FAIL alu_idle_wen: got %b want 0", WEN); end
    checks++; if (wsel !== 5'd5 || wdat !== 32'hDEADBEEF) begin errs++; $display("FAIL alu_idle_hold: got %0d/%h want 5/deadbeef", wsel, wdat); end
  endtask

  task automatic test_mdu_fill();
    alu_valid = 1'b1; alu_sel = 5'd7; alu_dat = 32'h7777;
    for (int i = 1; i <= 4; i++) begin
      mdu_valid = 1'b1; mdu_sel = 5'(i); mdu_dat = 32'h100 + i;
      tick();
      checks++; if (WEN !== 1'b1 || wsel !== 5'd7) begin errs++; $display("FAIL fill_alu_win%0d: got %b/%0d want 1/7", i, WEN, wsel); end
    end
    mdu_valid = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL fill_count: got %0d want 4", fifo_count); end
    checks++; if (mdu_ready !== 1'b0) begin errs++; $display("FAIL fill_mdu_ready: got %b want 0", mdu_ready); end
    checks++; if (pend_mask !== 32'h1E) begin errs++; $display("FAIL fill_pend: got %h want 1e", pend_mask); end
    checks++; if (alu_ready !== 1'b0) begin errs++; $display("FAIL fill_force: got alu_ready=%b want 0", alu_ready); end
    tick();
    checks++; if (WEN !== 1'b1 || wsel !== 5'd1 || wdat !== 32'h101) begin errs++; $display("FAIL fill_forced_pop: got %b/%0d/%h want 1/1/101", WEN, wsel, wdat); end
    checks++; if (alu_ready !== 1'b1 || fifo_count !== 3'd3) begin errs++; $display("FAIL fill_after_force: got rdy=%b cnt=%0d want 1/3", alu_ready, fifo_count); end
    alu_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++; if (WEN !== 1'b1 || wsel !== 5'(i) || wdat !== 32'h100 + i) begin errs++; $display("FAIL fill_drain%0d: got %b/%0d/%h", i, WEN, wsel, wdat); end
    end
    tick();
    checks++; if (WEN !== 1'b0 || fifo_count !== 3'd0) begin errs++; $display("FAIL fill_empty: got %b/%0d want 0/0", WEN, fifo_count); end
  endtask

  task automatic test_push_pop();
    logic [36:0] order[$];
    logic [36:0] e;
    alu_valid = 1'b1; alu_sel = 5'd9; alu_dat = 32'h9999;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) alu_valid = 1'b0;
      mdu_valid = 1'b1; mdu_sel = 5'(10 + k); mdu_dat = $urandom;
      order.push_back({mdu_sel, mdu_dat});
      #1;
      if (k >= 2) begin
        checks++; if (fifo_count !== 3'd2) begin errs++; $display("FAIL pp_count%0d: got %0d want 2", k, fifo_count); end
      end
      tick();
      if (k < 2) begin
        checks++; if (WEN !== 1'b1 || wsel !== 5'd9) begin errs++; $display("FAIL pp_alu%0d: got %b/%0d want 1/9", k, WEN, wsel); end
      end else begin
        e = order.pop_front();
        checks++; if ({WEN, wsel, wdat} !== {1'b1, e}) begin errs++; $display("FAIL pp_order%0d: got %b/%0d/%h want 1/%0d/%h", k, WEN, wsel, wdat, e[36:32], e[31:0]); end
      end
    end
    mdu_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      e = order.pop_front();
      checks++; if ({WEN, wsel, wdat} !== {1'b1, e}) begin errs++; $display("FAIL pp_tail%0d: got %b/%0d/%h want 1/%0d/%h", k, WEN, wsel, wdat, e[36:32], e[31:0]); end
    end
    tick();
  endtask

  task automatic test_x0();
    alu_valid = 1'b0;
    mdu_valid = 1'b1; mdu_sel = 5'd0; mdu_dat = 32'h5A5A;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errs++; $display("FAIL x0_mdu_ready: got %b want 1", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    checks++; if (fifo_count !== 3'd0 || WEN !== 1'b0) begin errs++; $display("FAIL x0_mdu_drop: got cnt=%0d wen=%b want 0/0", fifo_count, WEN); end
    alu_valid = 1'b1; alu_sel = 5'd3; alu_dat = 32'h33;
    mdu_valid = 1'b1; mdu_sel = 5'd6; mdu_dat = 32'h66;
    tick();
    mdu_valid = 1'b0; alu_sel = 5'd0; alu_dat = 32'hBAD;
    #1;
    checks++; if (fifo_count !== 3'd1 || alu_ready !== 1'b1) begin errs++; $display("FAIL x0_setup: got cnt=%0d rdy=%b want 1/1", fifo_count, alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (WEN !== 1'b1 || wsel !== 5'd6 || wdat !== 32'h66) begin errs++; $display("FAIL x0_alu_pop: got %b/%0d/%h want 1/6/66", WEN, wsel, wdat); end
    checks++; if (fifo_count !== 3'd0) begin errs++; $display("FAIL x0_alu_cnt: got %0d want 0", fifo_count); end
  endtask

  task automatic test_mid_reset();
    alu_valid = 1'b1; alu_sel = 5'd8; alu_dat = 32'h88;
    for (int i = 0; i < 3; i++) begin
      mdu_valid = 1'b1; mdu_sel = 5'(20 + i); mdu_dat = 32'hA0 + i;
      tick();
    end
    mdu_valid = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd3 || pend_mask !== 32'h0070_0000) begin errs++; $display("FAIL mr_setup: got cnt=%0d pend=%h want 3/00700000", fifo_count, pend_mask); end
    rst = 1'b1;
    tick();
    rst = 1'b0; alu_valid = 1'b0;
    checks++; if (fifo_count !== 3'd0 || pend_mask !== 32'd0 || WEN !== 1'b0) begin errs++; $display("FAIL mr_clear: got cnt=%0d pend=%h wen=%b want 0/0/0", fifo_count, pend_mask, WEN); end
    mdu_valid = 1'b1; mdu_sel = 5'd12; mdu_dat = 32'hC0FFEE;
    tick();
    mdu_valid = 1'b0;
    checks++; if (WEN !== 1'b0 || fifo_count !== 3'd1) begin errs++; $display("FAIL mr_lat1: got wen=%b cnt=%0d want 0/1", WEN, fifo_count); end
    tick();
    checks++; if (WEN !== 1'b1 || wsel !== 5'd12 || wdat !== 32'hC0FFEE) begin errs++; $display("FAIL mr_lat2: got %b/%0d/%h want 1/12/c0ffee", WEN, wsel, wdat); end
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_sel   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_dat   = $urandom;
      end
      mdu_valid = ($urandom_range(0, 99) < 50);
      mdu_sel   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdu_dat   = $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      #1;
      checks++; if ({alu_ready, mdu_ready} !== {m_alu_ready(), m_mdu_ready()})
        begin errs++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, alu_ready, mdu_ready, m_alu_ready(), m_mdu_ready()); end
      checks++; if (fifo_count !== 3'(m_q.size()) || pend_mask !== m_pend())
        begin errs++; $display("FAIL rnd_fifo c%0d: got %0d/%h want %0d/%h", c, fifo_count, pend_mask, m_q.size(), m_pend()); end
      hold = alu_valid && !m_alu_ready();
      tick();
      checks++; if ({WEN, wsel, wdat} !== {m_wen, m_wsel, m_wdat})
        begin errs++; $display("FAIL rnd_write c%0d: got %b/%0d/%h want %b/%0d/%h", c, WEN, wsel, wdat, m_wen, m_wsel, m_wdat); end
    end
    rst = 1'b0; alu_valid = 1'b0; mdu_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_sel = '0; alu_dat = '0;
    mdu_valid = 1'b0; mdu_sel = '0; mdu_dat = '0;
    test_reset();
    test_alu_only();
    test_mdu_fill();
    test_push_pop();
    test_x0();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
